reg_file: RTL
=============

# reg_file

Parametrised multi-port register file for the single-cycle processor datapath. It generalises the single read/write data register to DEPTH entries, NUM_READ independent synchronous read ports and one byte-masked write port, with read-during-write bypass on every port. It also provides an optional hard-wired zero register. It sits between the decode stage (register addresses) and the ALU/writeback path.

## Interface
- WIDTH, 32: data width in bits; must be a multiple of 8
- DEPTH, 32: number of entries; need not be a power of two
- NUM_READ, 2: number of read ports, 1..4
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_addr  in  AW  write address, AW = max(1, $clog2(DEPTH))
- wr_data  in  WIDTH  write data
- wr_mask  in  WIDTH/8  byte-lane enables, bit k covers wr_data[8k+7:8k]
- rd_en  in  NUM_READ  per-port read enable
- rd_addr  in  NUM_READ*AW  port i address at [i*AW +: AW]
- rd_data  out  NUM_READ*WIDTH  port i data at [i*WIDTH +: WIDTH], registered

## Operation
- Reset: while rst is high, all DEPTH entries and all rd_data are 0, independent of clk. Reset asserted mid-operation discards any write in that cycle.
- Effective write: wr_en=1, wr_addr<DEPTH, and not (ZERO_REG=1 and wr_addr=0). Only lanes with wr_mask[k]=1 update; other lanes keep their value. A mask of all zeros makes the write a no-op.
- Read port i with rd_en[i]=1 loads rd_data[i] with the entry at rd_addr[i] on the clock edge.
- Read port i with rd_en[i]=0 holds its previous rd_data[i]. This generalises the old read-hold behaviour.
- Bypass (write-first): when port i reads the address of an effective write in the same cycle, it returns the merged word: masked lanes come from wr_data, unmasked lanes from the stored value.
- Out-of-range rd_addr (≥DEPTH) returns 0.
- With ZERO_REG=1, address 0 always returns 0, with no bypass.
- Several ports may read the same address in the same cycle; all of them return the identical value.
- There are no error outputs. Illegal addresses are silently ignored or read as 0.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible to a non-bypassed read sampled at edge N+1 and later.
- Read latency: 1 cycle. rd_addr and rd_en sampled at edge N give rd_data valid after edge N.
- Bypass applies only to the same edge; there is no combinational path from any input to rd_data.
- After rst deasserts, the first active edge performs normal reads and writes.

## Structure
- No shared package types are needed.
- Derive AW and NLANE=WIDTH/8 as localparams inside the block. Also add an elaboration-time check that WIDTH%8==0 and 1≤NUM_READ≤4.
- The storage array and write logic live in reg_file.
- Sub-module reg_file_rd_port has one instance per read port, created by a generate loop. It contains the address range check, zero-register check, lane-wise bypass merge and output register.
- Its parameters are WIDTH, DEPTH, AW and ZERO_REG. Its inputs are the stored word, the write request and the port controls.

## Test plan
- Reset: write 0xDEADBEEF to addr 5, then pulse rst asynchronously between edges. rd_data goes 0 immediately; reading addr 5 afterwards returns 0x00000000.
- Write/read: write 0x12345678 to addr 3 with mask 4'hF, then read addr 3 on port 0 and addr 3 on port 1 in the next cycle. Both ports return 0x12345678 one cycle later.
- Byte mask plus bypass: addr 7 holds 0xAABBCCDD. In the same cycle, write 0x11223344 with mask 4'b0101 and read addr 7 on port 1. Port 1 returns 0xAA22CC44, and a later read also returns 0xAA22CC44.
- Zero register: write 0xFFFFFFFF to addr 0 while reading addr 0 in the same cycle, then read addr 0 again. Both reads return 0 (ZERO_REG=1). Repeat with ZERO_REG=0: the bypass read returns 0xFFFFFFFF.
- Hold and range: with DEPTH=20, read addr 2 (value 0x55) on port 0, then drop rd_en[0] for 3 cycles while changing rd_addr and writing addr 2. rd_data[0] stays 0x55. Reading addr 25 returns 0, and a write to addr 25 alters no entry.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and the address-width helper for the register file.
package reg_file_pkg;

  localparam int LANE_BITS = 8;
  localparam int MAX_READ  = 4;

  // A depth of 1 still needs a 1-bit address bus.
  function automatic int addr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One synchronous read port: range and zero-register checks, lane-wise
// write-first bypass merge, and the held output register.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           stored_word,
  input  logic                       wr_eff,
  input  logic [AW-1:0]              wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH/LANE_BITS-1:0] wr_mask,
  input  logic                       rd_en,
  input  logic [AW-1:0]              rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  localparam int NLANE = WIDTH / LANE_BITS;

  logic             in_range_s;
  logic             is_zero_s;
  logic             hit_s;
  logic [WIDTH-1:0] next_word_s;
  logic [WIDTH-1:0] rd_data_r;

  assign in_range_s = ({1'b0, rd_addr} < (AW+1)'(DEPTH));
  assign is_zero_s  = (ZERO_REG != 32'sd0) && (rd_addr == {AW{1'b0}});
  assign hit_s      = wr_eff && (wr_addr == rd_addr);

  // Select the value this port would load: zero, stored word, or bypass merge
  always_comb begin
    next_word_s = stored_word;
    if (!in_range_s || is_zero_s) begin
      next_word_s = {WIDTH{1'b0}};
    end else if (hit_s) begin
      for (int k = 0; k < NLANE; k++) begin
        if (wr_mask[k]) begin
          next_word_s[k*LANE_BITS +: LANE_BITS] = wr_data[k*LANE_BITS +: LANE_BITS];
        end else begin
          next_word_s[k*LANE_BITS +: LANE_BITS] = stored_word[k*LANE_BITS +: LANE_BITS];
        end
      end
    end else begin
      next_word_s = stored_word;
    end
  end

  // Output register; a disabled port keeps its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= next_word_s;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/reg_file.sv
// Multi-port register file: DEPTH entries, one byte-masked write port and
// NUM_READ registered read ports with write-first bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_READ = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH/LANE_BITS-1:0] wr_mask,
  input  logic [NUM_READ-1:0]        rd_en,
  input  logic [NUM_READ*AW-1:0]     rd_addr,
  output logic [NUM_READ*WIDTH-1:0]  rd_data
);

  localparam int NLANE = WIDTH / LANE_BITS;

  if (((WIDTH % LANE_BITS) != 32'sd0) || (NUM_READ < 32'sd1) || (NUM_READ > MAX_READ)) begin : g_param_check
    $error("reg_file: WIDTH must be a multiple of 8 and NUM_READ must be 1..4");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             wr_in_range_s;
  logic             wr_eff_s;
  logic [WIDTH-1:0] wr_cur_s;
  logic [WIDTH-1:0] wr_word_s;

  assign wr_in_range_s = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign wr_eff_s      = wr_en && wr_in_range_s &&
                         !((ZERO_REG != 32'sd0) && (wr_addr == {AW{1'b0}}));
  assign wr_cur_s      = wr_in_range_s ? mem_r[wr_addr] : {WIDTH{1'b0}};

  // Merge enabled byte lanes of the write data into the current entry
  always_comb begin
    wr_word_s = wr_cur_s;
    for (int k = 0; k < NLANE; k++) begin
      if (wr_mask[k]) begin
        wr_word_s[k*LANE_BITS +: LANE_BITS] = wr_data[k*LANE_BITS +: LANE_BITS];
      end else begin
        wr_word_s[k*LANE_BITS +: LANE_BITS] = wr_cur_s[k*LANE_BITS +: LANE_BITS];
      end
    end
  end

  // Storage array with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_r[e] <= {WIDTH{1'b0}};
      end
    end else if (wr_eff_s) begin
      mem_r[wr_addr] <= wr_word_s;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0]    addr_s;
    logic [WIDTH-1:0] word_s;

    assign addr_s = rd_addr[i*AW +: AW];
    assign word_s = ({1'b0, addr_s} < (AW+1)'(DEPTH)) ? mem_r[addr_s] : {WIDTH{1'b0}};

    reg_file_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .clk        (clk),
      .rst        (rst),
      .stored_word(word_s),
      .wr_eff     (wr_eff_s),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_mask    (wr_mask),
      .rd_en      (rd_en[i]),
      .rd_addr    (addr_s),
      .rd_data    (rd_data[i*WIDTH +: WIDTH])
    );
  end

endmodule
